// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage with a 2-entry skid buffer (main M = head, skid S = second), flush-to-NOP ctrl, occupancy and saturating bubble count; rst is synchronous active-low
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  bubble_cnt
);
  logic              m_v, s_v;
  logic [DATA_W-1:0] m_d, s_d;
  logic [CTRL_W-1:0] m_c, s_c;
  logic              in_fire, out_fire;
  assign in_ready  = rst & ~s_v & ~stall;
  assign out_valid = rst & m_v & ~stall;
  assign out_data  = m_d;
  assign out_ctrl  = out_valid ? m_c : '0;
  assign occ       = {1'b0, m_v} + {1'b0, s_v};
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  always_ff @(posedge clk) begin
    if (!rst) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
      m_d <= '0;
      s_d <= '0;
      m_c <= '0;
      s_c <= '0;
    end else if (flush) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
      m_c <= '0;
      s_c <= '0;
    end else if (!stall) begin
      if (!m_v || out_fire) begin
        if (s_v) begin
          m_v <= 1'b1;
          m_d <= s_d;
          m_c <= s_c;
          s_v <= 1'b0;
        end else begin
          m_v <= in_fire;
          if (in_fire) begin
            m_d <= in_data;
            m_c <= in_ctrl;
          end
        end
      end else if (in_fire) begin
        s_v <= 1'b1;
        s_d <= in_data;
        s_c <= in_ctrl;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst || cnt_clr) bubble_cnt <= '0;
    else if (!stall && out_ready && !m_v && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;
  logic        clk = 1'b0;
  logic        rst, stall, flush, cnt_clr, in_valid, out_ready;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_ready, out_valid, in_ready2, out_valid2;
  logic [31:0] out_data, out_data2;
  logic [7:0]  out_ctrl, out_ctrl2;
  logic [1:0]  occ, occ2;
  logic [15:0] bubble_cnt;
  logic [1:0]  bubble_cnt2;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  pipe_stage_skid dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occ(occ), .bubble_cnt(bubble_cnt)
  );
  pipe_stage_skid #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_ctrl(out_ctrl2),
    .occ(occ2), .bubble_cnt(bubble_cnt2)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic v, input logic [31:0] d, input logic [7:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask
  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
    put(1'b1, 32'hEE, 8'h01);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    tick();
    tick();
    chk("rst_occ", occ, 0);
    chk("rst_cnt", bubble_cnt, 0);
    chk("rst_cnt2", bubble_cnt2, 0);
    chk("rst_in_ready2", in_ready, 0);
    rst = 1'b1; out_ready = 1'b0; put(1'b0, 0, 0);
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_occ", occ, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      put(1'b1, 32'h11 + i, 8'(i + 1));
      #1;
      chk("stream_in_ready", in_ready, 1);
      tick();
      chk("stream_out_valid", out_valid, 1);
      chk("stream_out_data", out_data, 32'h11 + i);
      chk("stream_out_ctrl", out_ctrl, i + 1);
      chk("stream_occ", occ, 1);
    end
    put(1'b0, 0, 0);
    tick();
    chk("stream_drain_occ", occ, 0);
    chk("stream_drain_valid", out_valid, 0);
    chk("stream_cnt", bubble_cnt, 1);
    put(1'b1, 32'h21, 8'h00);
    tick();
    chk("bp_e1", out_data, 32'h21);
    put(1'b1, 32'h22, 8'h00);
    tick();
    chk("bp_e2", out_data, 32'h22);
    chk("bp_e2_occ", occ, 1);
    out_ready = 1'b0;
    put(1'b1, 32'h23, 8'h00);
    tick();
    chk("bp_full_occ", occ, 2);
    chk("bp_full_in_ready", in_ready, 0);
    chk("bp_hold_head", out_data, 32'h22);
    out_ready = 1'b1;
    put(1'b1, 32'h24, 8'h00);
    tick();
    chk("bp_e3", out_data, 32'h23);
    chk("bp_e3_occ", occ, 1);
    chk("bp_e3_in_ready", in_ready, 1);
    tick();
    chk("bp_e4", out_data, 32'h24);
    chk("bp_e4_occ", occ, 1);
    put(1'b0, 0, 0);
    tick();
    chk("bp_drain_occ", occ, 0);
    chk("bp_cnt", bubble_cnt, 2);
    out_ready = 1'b0;
    put(1'b1, 32'h31, 8'hA5);
    tick();
    put(1'b1, 32'h32, 8'hA5);
    tick();
    chk("fl_pre_occ", occ, 2);
    chk("fl_pre_ctrl", out_ctrl, 8'hA5);
    flush = 1'b1;
    put(1'b1, 32'h33, 8'h5A);
    tick();
    chk("fl_occ", occ, 0);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_out_ctrl", out_ctrl, 0);
    chk("fl_m_data", out_data, 32'h31);
    chk("fl_s_data", dut.s_d, 32'h32);
    chk("fl_m_ctrl", dut.m_c, 0);
    put(1'b1, 32'h34, 8'h5A);
    #1;
    chk("fl_empty_in_ready", in_ready, 1);
    tick();
    flush = 1'b0;
    chk("fl_drop_occ", occ, 0);
    chk("fl_drop_data", out_data, 32'h31);
    put(1'b1, 32'h41, 8'h07);
    tick();
    chk("st_load_occ", occ, 1);
    stall = 1'b1; out_ready = 1'b1;
    put(1'b1, 32'h42, 8'h09);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_out_valid", out_valid, 0);
      chk("st_in_ready", in_ready, 0);
      chk("st_out_ctrl", out_ctrl, 0);
      tick();
      chk("st_occ", occ, 1);
      chk("st_cnt", bubble_cnt, 2);
    end
    stall = 1'b0;
    put(1'b0, 0, 0);
    #1;
    chk("st_rel_valid", out_valid, 1);
    chk("st_rel_data", out_data, 32'h41);
    chk("st_rel_ctrl", out_ctrl, 8'h07);
    tick();
    chk("st_rel_occ", occ, 0);
    chk("st_rel_cnt", bubble_cnt, 2);
    chk("st_rel_cnt2", bubble_cnt2, 2);
    cnt_clr = 1'b1;
    tick();
    chk("cnt_clr_first", bubble_cnt2, 0);
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("cnt_sat", bubble_cnt2, (i < 3) ? i + 1 : 3);
    end
    chk("cnt_wide", bubble_cnt, 5);
    cnt_clr = 1'b1;
    tick();
    chk("cnt_clr_sat", bubble_cnt2, 0);
    cnt_clr = 1'b0; out_ready = 1'b1;
    put(1'b1, 32'h51, 8'h03);
    tick();
    chk("mid_load_valid", out_valid, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    tick();
    rst = 1'b1;
    put(1'b0, 0, 0);
    #1;
    chk("mid_rst_occ", occ, 0);
    chk("mid_rst_data", out_data, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
